// File: rtl/score_accumulator_if.sv
// Point-entry / score bus for one team's score_accumulator.
// master: upstream button logic + display consumers (drives add_en, points,
//         undo, clear; reads score, tens, units, hundreds, buzzer, locked)
// slave : the score_accumulator itself
interface score_accumulator_if;
    logic       add_en;
    logic [1:0] points;
    logic       undo;
    logic       clear;
    logic [6:0] score;
    logic [3:0] tens;
    logic [3:0] units;
    logic       hundreds;
    logic       buzzer;
    logic       locked;

    modport master (
        output add_en, points, undo, clear,
        input  score, tens, units, hundreds, buzzer, locked
    );

    modport slave (
        input  add_en, points, undo, clear,
        output score, tens, units, hundreds, buzzer, locked
    );
endinterface

// File: rtl/score_accumulator.sv
// Basketball score counter for one team: 1/2/3-point adds, one-level undo,
// buzzer for BUZZ_CYCLES cycles on reaching 100, then locked until clear.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      score_accumulator_if.slave (entry pulses in, score/BCD/buzzer out)
module score_accumulator #(
    parameter int unsigned BUZZ_CYCLES = 50_000_000
) (
    input logic               clk,
    input logic               reset_n,
    score_accumulator_if.slave bus
);

    localparam int unsigned SCORE_W = 7;
    localparam int unsigned TIMER_W = $clog2(BUZZ_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_COUNT  = 2'd0,
        ST_BUZZ   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state_q;
    logic [SCORE_W-1:0]   score_q;
    logic [1:0]           last_pts_q;
    logic                 hist_valid_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 buzzer_q;
    logic                 locked_q;

    // Candidate next scores for an add and for an undo.
    logic [SCORE_W-1:0]   sum_d;
    logic [SCORE_W-1:0]   diff_d;

    assign sum_d  = score_q + SCORE_W'(bus.points);
    assign diff_d = score_q - SCORE_W'(last_pts_q);

    // Scoring FSM; clear wins over everything, add wins over undo.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_COUNT;
            score_q      <= '0;
            last_pts_q   <= '0;
            hist_valid_q <= 1'b0;
            timer_q      <= '0;
            buzzer_q     <= 1'b0;
            locked_q     <= 1'b0;
        end else if (bus.clear) begin
            state_q      <= ST_COUNT;
            score_q      <= '0;
            hist_valid_q <= 1'b0;
            timer_q      <= '0;
            buzzer_q     <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (bus.add_en) begin
                        // points==0 is a no-op that still swallows a same-cycle undo
                        if (bus.points != 2'd0) begin
                            score_q      <= sum_d;
                            last_pts_q   <= bus.points;
                            hist_valid_q <= 1'b1;
                            if (sum_d >= SCORE_W'(100)) begin
                                state_q  <= ST_BUZZ;
                                buzzer_q <= 1'b1;
                                locked_q <= 1'b1;
                                timer_q  <= TIMER_W'(BUZZ_CYCLES - 1);
                            end
                        end
                    end else if (bus.undo && hist_valid_q) begin
                        score_q      <= diff_d;
                        hist_valid_q <= 1'b0;
                    end
                end
                ST_BUZZ: begin
                    if (timer_q == '0) begin
                        buzzer_q <= 1'b0;
                        state_q  <= ST_LOCKED;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                ST_LOCKED: begin
                    state_q <= ST_LOCKED;
                end
                default: begin
                    state_q <= ST_COUNT;
                end
            endcase
        end
    end

    // Display decode: score never exceeds 102, so one conditional subtract suffices.
    logic [SCORE_W-1:0] rem_c;
    logic               hundreds_c;

    always_comb begin
        hundreds_c = (score_q >= SCORE_W'(100));
        rem_c      = score_q;
        if (hundreds_c) begin
            rem_c = score_q - SCORE_W'(100);
        end
    end

    assign bus.score    = score_q;
    assign bus.hundreds = hundreds_c;
    assign bus.tens     = 4'(rem_c / SCORE_W'(10));
    assign bus.units    = 4'(rem_c % SCORE_W'(10));
    assign bus.buzzer   = buzzer_q;
    assign bus.locked   = locked_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Bench for score_accumulator (BUZZ_CYCLES=4): directed scoring sequences,
// a behavioural scoreboard model compared every falling edge, plus literal
// spot checks of hand-computed values.
module tb_score_accumulator;

    localparam int BUZZ = 4;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    score_accumulator_if bus();

    score_accumulator #(.BUZZ_CYCLES(BUZZ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard model: score as an integer, remaining buzzer cycles as a
    // countdown, lock flag, and last accepted points (0 = no undo available).
    int m_score     = 0;
    int m_last      = 0;
    int m_buzz_left = 0;
    bit m_locked    = 1'b0;
    bit cmp_en      = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_score     <= 0;
            m_last      <= 0;
            m_buzz_left <= 0;
            m_locked    <= 1'b0;
        end else if (bus.clear) begin
            m_score     <= 0;
            m_last      <= 0;
            m_buzz_left <= 0;
            m_locked    <= 1'b0;
        end else if (m_locked) begin
            if (m_buzz_left > 0) m_buzz_left <= m_buzz_left - 1;
        end else if (bus.add_en) begin
            if (bus.points != 2'd0) begin
                m_score <= m_score + int'(bus.points);
                m_last  <= int'(bus.points);
                if (m_score + int'(bus.points) >= 100) begin
                    m_locked    <= 1'b1;
                    m_buzz_left <= BUZZ;
                end
            end
        end else if (bus.undo && m_last != 0) begin
            m_score <= m_score - m_last;
            m_last  <= 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp.score",    int'(bus.score),    m_score);
            check("cmp.tens",     int'(bus.tens),     (m_score % 100) / 10);
            check("cmp.units",    int'(bus.units),    m_score % 10);
            check("cmp.hundreds", int'(bus.hundreds), int'(m_score >= 100));
            check("cmp.buzzer",   int'(bus.buzzer),   int'(m_buzz_left > 0));
            check("cmp.locked",   int'(bus.locked),   int'(m_locked));
        end
    end

    // One clock edge with the given pulses; returns 1 time unit after the edge.
    task automatic step(input logic a, input logic [1:0] p, input logic u, input logic c);
        bus.add_en = a;
        bus.points = p;
        bus.undo   = u;
        bus.clear  = c;
        @(posedge clk);
        #1;
        bus.add_en = 1'b0;
        bus.points = 2'd0;
        bus.undo   = 1'b0;
        bus.clear  = 1'b0;
    endtask

    task automatic add(input logic [1:0] p);
        step(1'b1, p, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".score"},    int'(bus.score),    0);
        check({tag, ".tens"},     int'(bus.tens),     0);
        check({tag, ".units"},    int'(bus.units),    0);
        check({tag, ".hundreds"}, int'(bus.hundreds), 0);
        check({tag, ".buzzer"},   int'(bus.buzzer),   0);
        check({tag, ".locked"},   int'(bus.locked),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        bus.add_en = 1'b0;
        bus.points = 2'd0;
        bus.undo   = 1'b0;
        bus.clear  = 1'b0;
        reset_n    = 1'b1;
        #1 reset_n = 1'b0;
        #3;
        check_all_zero("reset");
        cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic adds 3, 2, 1.
        add(2'd3); check("add3.score", int'(bus.score), 3);
        add(2'd2); check("add2.score", int'(bus.score), 5);
        add(2'd1); check("add1.score", int'(bus.score), 6);
        check("add1.tens",   int'(bus.tens),   0);
        check("add1.units",  int'(bus.units),  6);
        check("add1.buzzer", int'(bus.buzzer), 0);

        // Climb to 97, then cross 100.
        for (int i = 0; i < 30; i++) add(2'd3);
        add(2'd1);
        check("s97.score", int'(bus.score), 97);
        check("s97.tens",  int'(bus.tens),  9);
        check("s97.units", int'(bus.units), 7);
        add(2'd3);
        check("x100.score",    int'(bus.score),    100);
        check("x100.hundreds", int'(bus.hundreds), 1);
        check("x100.tens",     int'(bus.tens),     0);
        check("x100.units",    int'(bus.units),    0);
        check("x100.buzzer",   int'(bus.buzzer),   1);
        check("x100.locked",   int'(bus.locked),   1);
        add(2'd2);
        check("buzz1.score",  int'(bus.score),  100);
        check("buzz1.buzzer", int'(bus.buzzer), 1);
        idle(); check("buzz2.buzzer", int'(bus.buzzer), 1);
        idle(); check("buzz3.buzzer", int'(bus.buzzer), 1);
        idle();
        check("buzz4.buzzer", int'(bus.buzzer), 0);
        check("buzz4.locked", int'(bus.locked), 1);
        add(2'd2);
        check("lock.add.score", int'(bus.score), 100);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("lock.undo.score", int'(bus.score), 100);

        // Clear leaves lock; undo sequence at 40.
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("clr.score",  int'(bus.score),  0);
        check("clr.locked", int'(bus.locked), 0);
        for (int i = 0; i < 13; i++) add(2'd3);
        add(2'd1);
        check("s40.score", int'(bus.score), 40);
        add(2'd2);
        check("u.add.score", int'(bus.score), 42);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("u.undo1.score", int'(bus.score), 40);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("u.undo2.score", int'(bus.score), 40);
        add(2'd0);
        check("u.zero.score", int'(bus.score), 40);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("u.undo3.score", int'(bus.score), 40);

        // Add and undo in the same cycle at 50.
        add(2'd3); add(2'd3); add(2'd3); add(2'd1);
        check("s50.score", int'(bus.score), 50);
        step(1'b1, 2'd3, 1'b1, 1'b0);
        check("addundo.score", int'(bus.score), 53);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("addundo.undo.score", int'(bus.score), 50);

        // Clear mid-buzz.
        for (int i = 0; i < 16; i++) add(2'd3);
        add(2'd2);
        check("x100b.buzzer", int'(bus.buzzer), 1);
        idle();
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("midclr.score",  int'(bus.score),  0);
        check("midclr.buzzer", int'(bus.buzzer), 0);
        check("midclr.locked", int'(bus.locked), 0);
        add(2'd1);
        check("midclr.add.score", int'(bus.score), 1);
        repeat (5) idle();
        check("midclr.quiet.buzzer", int'(bus.buzzer), 0);

        // Asynchronous reset while buzzing.
        for (int i = 0; i < 33; i++) add(2'd3);
        check("x100c.buzzer", int'(bus.buzzer), 1);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("areset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        add(2'd2);
        check("post.reset.score", int'(bus.score), 2);
        idle();

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
